vend_ctrl_param: RTL and testbench

Parametrised next-generation vending controller: cash (quarter/dollar) and card payment, NUM_ITEMS selectable slots with per-slot run-time prices and stock-empty flags, and timed status messages.
- Returns change as quarter pulses.
- Sits between the front-panel input debouncers and the dispenser/display drivers.
- All money is counted in quarter units.

---
 rtl/vend_pkg.sv | 38 +++
 rtl/vend_ctrl_param_msg_timer.sv | 31 +++
 rtl/vend_ctrl_param.sv | 219 +++++++++++++++++++++
 tb/tb_vend_ctrl_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: state encoding, timer sizing
// and one-hot select helpers.
package vend_pkg;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_COLLECT    = 4'd1,
      S_SELECT     = 4'd2,
      S_EMPTY      = 4'd3,
      S_CHECK      = 4'd4,
      S_VEND       = 4'd5,
      S_SHORT      = 4'd6,
      S_CHANGE     = 4'd7,
      S_CARD_SEL   = 4'd8,
      S_CARD_EMPTY = 4'd9,
      S_CARD_VEND  = 4'd10
   } state_t;

   // Select helpers operate on a fixed-width vector; callers zero-extend.
   localparam int MAX_ITEMS = 32;

   function automatic int tmr_w(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

   function automatic logic onehot_ok(input logic [MAX_ITEMS-1:0] v);
      return (v != '0) && ((v & (v - MAX_ITEMS'(1))) == '0);
   endfunction

   function automatic logic [4:0] onehot_idx(input logic [MAX_ITEMS-1:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_ITEMS; i++)
         if (v[i]) idx = 5'(i);
      return idx;
   endfunction

endpackage

// File: rtl/vend_ctrl_param_msg_timer.sv
// Elapsed-cycle counter for timed message states: load marks the first cycle
// in a state, expire marks the last of CYCLES cycles.
module msg_timer
   import vend_pkg::*;
#(
   parameter int CYCLES = 25,
   parameter int W      = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic expire
);

   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (load)
         cnt_q <= W'(1);
      else if (cnt_q != LAST)
         cnt_q <= cnt_q + 1'b1;
   end

   // On the load cycle the count is stale, so only a one-cycle message expires.
   assign expire = load ? (CYCLES <= 1) : (cnt_q == LAST);

endmodule

// File: rtl/vend_ctrl_param.sv
// Cash/card vending controller with timed status messages and quarter change.
// Optional cancel input enabled by defining VEND_CANCEL_EN.
module vend_ctrl_param
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS  = 8,
   parameter int PRICE_W    = 6,
   parameter int BAL_W      = 8,
   parameter int DOLLAR_Q   = 4,
   parameter int MSG_CYCLES = 25
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cash_sel,
   input  logic                         card_sel,
   input  logic                         quarter_in,
   input  logic                         dollar_in,
   input  logic                         done,
`ifdef VEND_CANCEL_EN
   input  logic                         cancel,
`endif
   input  logic [NUM_ITEMS-1:0]         item_sel,
   input  logic [NUM_ITEMS-1:0]         item_empty,
   input  logic [NUM_ITEMS*PRICE_W-1:0] price_tbl,
   output logic [3:0]                   state,
   output logic [BAL_W-1:0]             balance,
   output logic                         vend,
   output logic                         empty_msg,
   output logic                         short_msg,
   output logic                         change,
   output logic                         busy
);

   localparam int SLOT_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam int TMR_W  = tmr_w(MSG_CYCLES);
   localparam int CMP_W  = (BAL_W > PRICE_W) ? BAL_W : PRICE_W;
   localparam logic [31:0] BAL_MAX = 32'((64'd1 << BAL_W) - 64'd1);

   function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] b,
                                                input logic q, input logic d);
      logic [31:0] s;
      s = 32'(b) + (q ? 32'd1 : 32'd0) + (d ? 32'(DOLLAR_Q) : 32'd0);
      return (s > BAL_MAX) ? BAL_MAX[BAL_W-1:0] : s[BAL_W-1:0];
   endfunction

   state_t             state_q;
   logic [BAL_W-1:0]   bal_q;
   logic [SLOT_W-1:0]  slot_q;
   logic               vend_q, empty_q, short_q, change_q, tmr_load_q;
   logic               tmr_exp;
   logic               cancel_w;

`ifdef VEND_CANCEL_EN
   assign cancel_w = cancel;
`else
   assign cancel_w = 1'b0;
`endif

   logic [MAX_ITEMS-1:0] sel_ext;
   logic                 sel_ok;
   logic [SLOT_W-1:0]    sel_idx;
   logic                 sel_empty;
   logic [PRICE_W-1:0]   price;
   logic                 can_buy;
   logic [BAL_W-1:0]     bal_add;
   logic [BAL_W-1:0]     bal_diff;

   assign sel_ext   = MAX_ITEMS'(item_sel);
   assign sel_ok    = onehot_ok(sel_ext);
   assign sel_idx   = SLOT_W'(onehot_idx(sel_ext));
   assign sel_empty = item_empty[sel_idx];
   assign price     = price_tbl[int'(slot_q)*PRICE_W +: PRICE_W];
   assign can_buy   = CMP_W'(bal_q) >= CMP_W'(price);
   assign bal_add   = sat_add(bal_q, quarter_in, dollar_in);
   // Only used when can_buy holds, so truncating the price cannot lose bits.
   assign bal_diff  = bal_q - BAL_W'(price);

   msg_timer #(.CYCLES(MSG_CYCLES), .W(TMR_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load_q),
      .expire (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bal_q      <= '0;
         slot_q     <= '0;
         vend_q     <= 1'b0;
         empty_q    <= 1'b0;
         short_q    <= 1'b0;
         change_q   <= 1'b0;
         tmr_load_q <= 1'b0;
      end else begin
         tmr_load_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cash_sel)      state_q <= S_COLLECT;
               else if (card_sel) state_q <= S_CARD_SEL;
            end
            S_COLLECT: begin
               bal_q <= bal_add;
               if (cancel_w) begin
                  state_q  <= S_CHANGE;
                  change_q <= |bal_add;
               end else if (done) begin
                  state_q <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (cancel_w) begin
                  state_q  <= S_CHANGE;
                  change_q <= |bal_q;
               end else if (sel_ok) begin
                  slot_q <= sel_idx;
                  if (sel_empty) begin
                     state_q    <= S_EMPTY;
                     empty_q    <= 1'b1;
                     tmr_load_q <= 1'b1;
                  end else begin
                     state_q <= S_CHECK;
                  end
               end
            end
            S_EMPTY: begin
               if (tmr_exp) begin
                  empty_q <= 1'b0;
                  state_q <= S_SELECT;
               end
            end
            S_CHECK: begin
               tmr_load_q <= 1'b1;
               if (can_buy) begin
                  bal_q   <= bal_diff;
                  state_q <= S_VEND;
                  vend_q  <= 1'b1;
               end else begin
                  state_q <= S_SHORT;
                  short_q <= 1'b1;
               end
            end
            S_VEND: begin
               if (tmr_exp) begin
                  vend_q <= 1'b0;
                  if (bal_q != '0) begin
                     state_q  <= S_CHANGE;
                     change_q <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_SHORT: begin
               if (cancel_w) begin
                  short_q  <= 1'b0;
                  state_q  <= S_CHANGE;
                  change_q <= |bal_q;
               end else if (tmr_exp) begin
                  short_q <= 1'b0;
                  state_q <= S_COLLECT;
               end
            end
            S_CHANGE: begin
               // Alternate high/low; leave once the last quarter has been paid.
               if (change_q) begin
                  change_q <= 1'b0;
                  bal_q    <= bal_q - 1'b1;
                  if (bal_q == BAL_W'(1)) state_q <= S_IDLE;
               end else if (bal_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  change_q <= 1'b1;
               end
            end
            S_CARD_SEL: begin
               if (cancel_w) begin
                  state_q <= S_IDLE;
               end else if (sel_ok) begin
                  slot_q     <= sel_idx;
                  tmr_load_q <= 1'b1;
                  if (sel_empty) begin
                     state_q <= S_CARD_EMPTY;
                     empty_q <= 1'b1;
                  end else begin
                     state_q <= S_CARD_VEND;
                     vend_q  <= 1'b1;
                  end
               end
            end
            S_CARD_EMPTY: begin
               if (cancel_w) begin
                  empty_q <= 1'b0;
                  state_q <= S_IDLE;
               end else if (tmr_exp) begin
                  empty_q <= 1'b0;
                  state_q <= S_CARD_SEL;
               end
            end
            S_CARD_VEND: begin
               if (tmr_exp) begin
                  vend_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign state     = state_q;
   assign balance   = bal_q;
   assign vend      = vend_q;
   assign empty_msg = empty_q;
   assign short_msg = short_q;
   assign change    = change_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: expected values queued at stimulus time,
// popped and compared when the DUT response is sampled.
module tb_vend_ctrl_param;

   localparam logic [31:0] ST_IDLE = 0, ST_COLLECT = 1, ST_SELECT = 2, ST_CHECK = 4,
                           ST_VEND = 5, ST_SHORT = 6, ST_CHANGE = 7, ST_CARD_SEL = 8,
                           ST_CARD_EMPTY = 9, ST_CARD_VEND = 10;

   logic        clk = 1'b0;
   logic        rst, cash_sel, card_sel, quarter_in, dollar_in, done;
   logic        cancel;
   logic [7:0]  item_sel, item_empty;
   logic [47:0] price_tbl;
   logic [3:0]  state;
   logic [7:0]  balance;
   logic        vend, empty_msg, short_msg, change, busy;

   logic        rst_b, cash_b, dollar_b, done_b;
   logic [3:0]  state_b;
   logic [3:0]  balance_b;
   logic        vend_b, empty_b, short_b, change_b, busy_b;
   logic        zero1 = 1'b0;
   logic [7:0]  zero8 = 8'd0;

   always #5 clk = ~clk;

   vend_ctrl_param dut (
      .clk(clk), .rst(rst), .cash_sel(cash_sel), .card_sel(card_sel),
      .quarter_in(quarter_in), .dollar_in(dollar_in), .done(done),
`ifdef VEND_CANCEL_EN
      .cancel(cancel),
`endif
      .item_sel(item_sel), .item_empty(item_empty), .price_tbl(price_tbl),
      .state(state), .balance(balance), .vend(vend), .empty_msg(empty_msg),
      .short_msg(short_msg), .change(change), .busy(busy)
   );

   vend_ctrl_param #(.BAL_W(4)) dut_b (
      .clk(clk), .rst(rst_b), .cash_sel(cash_b), .card_sel(zero1),
      .quarter_in(zero1), .dollar_in(dollar_b), .done(done_b),
`ifdef VEND_CANCEL_EN
      .cancel(zero1),
`endif
      .item_sel(zero8), .item_empty(zero8), .price_tbl(price_tbl),
      .state(state_b), .balance(balance_b), .vend(vend_b), .empty_msg(empty_b),
      .short_msg(short_b), .change(change_b), .busy(busy_b)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) passed++;
         else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
   endtask

   // Bounded measurement helpers.
   task automatic count_high_vend(output int n);
      n = 0;
      while (vend === 1'b1 && n < 200) begin n++; tick(); end
   endtask

   task automatic count_high_short(output int n);
      n = 0;
      while (short_msg === 1'b1 && n < 200) begin n++; tick(); end
   endtask

   task automatic count_high_empty(output int n);
      n = 0;
      while (empty_msg === 1'b1 && n < 200) begin n++; tick(); end
   endtask

   task automatic count_change(output int pulses);
      int n;
      n = 0;
      pulses = 0;
      while (state == 4'(ST_CHANGE) && n < 200) begin
         if (change === 1'b1) pulses++;
         n++;
         tick();
      end
   endtask

   task automatic pulse(ref logic sig);
      sig = 1'b1; tick(); sig = 1'b0;
   endtask

   initial begin
      int n;
      int prices[8] = '{2, 3, 4, 6, 5, 7, 8, 9};
      for (int i = 0; i < 8; i++) price_tbl[i*6 +: 6] = 6'(prices[i]);
      rst = 1'b1; cash_sel = 0; card_sel = 0; quarter_in = 0; dollar_in = 0;
      done = 0; cancel = 0; item_sel = 0; item_empty = 0;
      rst_b = 1'b1; cash_b = 0; dollar_b = 0; done_b = 0;
      tick(); tick();
      rst = 1'b0; rst_b = 1'b0;

      // Reset state
      expect_v("rst_state", ST_IDLE);   expect_v("rst_balance", 0);
      expect_v("rst_vend", 0);          expect_v("rst_empty", 0);
      expect_v("rst_short", 0);         expect_v("rst_change", 0);
      expect_v("rst_busy", 0);
      observe(32'(state)); observe(32'(balance)); observe(32'(vend));
      observe(32'(empty_msg)); observe(32'(short_msg)); observe(32'(change));
      observe(32'(busy));

      // Cash: 2 dollars + quarter (with done) = 9, slot 4 price 5
      expect_v("t1_collect", ST_COLLECT); expect_v("t1_busy", 1);
      pulse(cash_sel);
      observe(32'(state)); observe(32'(busy));
      pulse(dollar_in); pulse(dollar_in);
      quarter_in = 1; done = 1; tick(); quarter_in = 0; done = 0;
      expect_v("t1_select", ST_SELECT); expect_v("t1_balance", 9);
      observe(32'(state)); observe(32'(balance));
      item_sel = 8'b0001_0000; tick(); item_sel = 0;
      expect_v("t1_check", ST_CHECK); observe(32'(state));
      tick();
      expect_v("t1_vend_state", ST_VEND); expect_v("t1_bal_after", 4);
      observe(32'(state)); observe(32'(balance));
      expect_v("t1_vend_len", 25); count_high_vend(n); observe(32'(n));
      expect_v("t1_change_pulses", 4); count_change(n); observe(32'(n));
      expect_v("t1_end_state", ST_IDLE); expect_v("t1_end_bal", 0);
      observe(32'(state)); observe(32'(balance));

      // Cash: 1 quarter, slot 0 price 2 -> short, then top up and vend
      pulse(cash_sel); pulse(quarter_in); pulse(done);
      item_sel = 8'b0000_0001; tick(); item_sel = 0; tick();
      expect_v("t2_short_state", ST_SHORT); observe(32'(state));
      expect_v("t2_short_len", 25); count_high_short(n); observe(32'(n));
      expect_v("t2_back_collect", ST_COLLECT); expect_v("t2_bal_kept", 1);
      observe(32'(state)); observe(32'(balance));
      quarter_in = 1; done = 1; tick(); quarter_in = 0; done = 0;
      expect_v("t2_bal2", 2); observe(32'(balance));
      item_sel = 8'b0000_0001; tick(); item_sel = 0; tick();
      expect_v("t2_vend_len", 25); count_high_vend(n); observe(32'(n));
      expect_v("t2_idle_no_change", ST_IDLE); expect_v("t2_change_low", 0);
      observe(32'(state)); observe(32'(change));

      // Card: slot 3 empty, then slot 2
      item_empty = 8'b0000_1000;
      pulse(card_sel);
      expect_v("t3_card_sel", ST_CARD_SEL); observe(32'(state));
      item_sel = 8'b0000_1000; tick(); item_sel = 0;
      expect_v("t3_card_empty", ST_CARD_EMPTY); observe(32'(state));
      expect_v("t3_empty_len", 25); count_high_empty(n); observe(32'(n));
      expect_v("t3_back_card_sel", ST_CARD_SEL); observe(32'(state));
      item_sel = 8'b0000_0100; tick(); item_sel = 0;
      expect_v("t3_card_vend", ST_CARD_VEND); observe(32'(state));
      expect_v("t3_vend_len", 25); count_high_vend(n); observe(32'(n));
      expect_v("t3_idle", ST_IDLE); expect_v("t3_bal", 0);
      observe(32'(state)); observe(32'(balance));
      item_empty = 0;

      // Quarter+dollar together, then invalid multi-hot select holds SELECT
      pulse(cash_sel);
      quarter_in = 1; dollar_in = 1; tick(); quarter_in = 0; dollar_in = 0;
      expect_v("t4_qd_bal", 5); observe(32'(balance));
      pulse(done);
      item_sel = 8'b0000_0011;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (state == 4'(ST_SELECT)) n++;
      end
      expect_v("t4_multihot_hold", 10); observe(32'(n));
      item_sel = 8'b0000_0000; tick();
      expect_v("t4_zero_hold", ST_SELECT); observe(32'(state));
      rst = 1; tick(); rst = 0;

      // Reset on VEND cycle 10
      pulse(cash_sel); pulse(dollar_in); pulse(dollar_in); pulse(done);
      item_sel = 8'b0001_0000; tick(); item_sel = 0; tick();
      for (int i = 0; i < 9; i++) tick();
      expect_v("t5_vend_still", 1); observe(32'(vend));
      rst = 1; tick(); rst = 0;
      expect_v("t5_state", ST_IDLE); expect_v("t5_vend", 0); expect_v("t5_bal", 0);
      observe(32'(state)); observe(32'(vend)); observe(32'(balance));

      // Saturation on the BAL_W=4 instance
      cash_b = 1; tick(); cash_b = 0;
      for (int i = 0; i < 5; i++) begin dollar_b = 1; tick(); dollar_b = 0; end
      expect_v("t6_sat_bal", 15); expect_v("t6_sat_busy", 1);
      observe(32'(balance_b)); observe(32'(busy_b));
      tick();
      expect_v("t6_no_coins_out_of_collect", 15); observe(32'(balance_b));

`ifdef VEND_CANCEL_EN
      // Cancel in SELECT refunds the full balance as quarters
      pulse(cash_sel); pulse(quarter_in); pulse(quarter_in); pulse(quarter_in);
      pulse(done);
      cancel = 1; tick(); cancel = 0;
      expect_v("t7_change_state", ST_CHANGE); observe(32'(state));
      expect_v("t7_refund_pulses", 3); count_change(n); observe(32'(n));
      expect_v("t7_idle", ST_IDLE); expect_v("t7_no_vend", 0);
      observe(32'(state)); observe(32'(vend));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
